// File: rtl/spike_scheduler_if.sv
// Handshake bundle between the scheduler and the self-timed spiking network.
interface spike_scheduler_if #(
    parameter int unsigned NEURON_IN  = 4,
    parameter int unsigned NEURON_OUT = 2
);
    logic [NEURON_IN-1:0]  req_in;
    logic [NEURON_IN-1:0]  ack_in;
    logic [NEURON_OUT-1:0] req_out;
    logic [NEURON_OUT-1:0] ack_out;

    modport master (output req_in, input ack_in, input req_out, output ack_out);
    modport slave  (input req_in, output ack_in, output req_out, input ack_out);
endinterface

// File: rtl/spike_scheduler.sv
// Sequences budgeted input spikes into the network round-robin (one 4-phase
// handshake at a time) and acknowledges/counts the network's output spikes.
module spike_scheduler #(
    parameter int unsigned NEURON_IN  = 4,
    parameter int unsigned NEURON_OUT = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GAP        = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [$clog2(NEURON_IN)-1:0] load_idx,
    input  logic [CNT_W-1:0]             load_cnt,
    input  logic                         start,
    input  logic                         clr_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [NEURON_OUT*CNT_W-1:0]  spike_cnt,
    spike_scheduler_if.master            net
);
    localparam int unsigned IDX_W = $clog2(NEURON_IN);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_REL, S_GAP} state_t;

    state_t                state, state_d;
    logic [NEURON_IN-1:0]  ack_s1, ack_s2;
    logic [NEURON_OUT-1:0] rq_s1, rq_s2;
    logic [CNT_W-1:0]      budget [NEURON_IN];
    logic [IDX_W-1:0]      ptr, grant, grant_d, sel;
    logic                  sel_ok;
    logic [TMR_W-1:0]      tmr;
    logic [GAP_W-1:0]      gcnt;
    logic [NEURON_IN-1:0]  req_in_q, req_in_d;
    logic [NEURON_OUT-1:0] ack_out_q;
    logic                  busy_d, done_d, err_d;
    logic                  ack_g, tmr_hit, gap_hit, tmo, step;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                   input int unsigned off);
        return IDX_W'((32'(base) + off) % NEURON_IN);
    endfunction

    assign net.req_in  = req_in_q;
    assign net.ack_out = ack_out_q;
    assign ack_g       = ack_s2[grant];
    assign tmr_hit     = (tmr == TMR_W'(TIMEOUT - 1));
    assign gap_hit     = (gcnt == GAP_W'(GAP - 1));

    // Two-flop synchronizers for the self-timed handshake inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_s1 <= '0;
            ack_s2 <= '0;
            rq_s1  <= '0;
            rq_s2  <= '0;
        end else begin
            ack_s1 <= net.ack_in;
            ack_s2 <= ack_s1;
            rq_s1  <= net.req_out;
            rq_s2  <= rq_s1;
        end
    end

    // Round-robin pick: first non-empty budget at or after ptr, wrapping.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        for (int i = int'(NEURON_IN) - 1; i >= 0; i--) begin
            if (budget[wrap_idx(ptr, unsigned'(i))] != '0) begin
                sel    = wrap_idx(ptr, unsigned'(i));
                sel_ok = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: if (start) state_d = S_ARB;
            S_ARB:  state_d = sel_ok ? S_REQ : S_IDLE;
            S_REQ: begin
                if (ack_g)        state_d = S_REL;
                else if (tmr_hit) state_d = S_IDLE;
            end
            S_REL: begin
                if (!ack_g)       state_d = (GAP == 0) ? S_ARB : S_GAP;
                else if (tmr_hit) state_d = S_IDLE;
            end
            S_GAP:  if (gap_hit) state_d = S_ARB;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: next values for the registered status and request lines.
    always_comb begin
        grant_d  = grant;
        req_in_d = '0;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = err;
        tmo      = 1'b0;
        step     = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                busy_d = 1'b1;
                err_d  = 1'b0;
            end
            S_ARB: begin
                if (sel_ok) begin
                    grant_d = sel;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_REQ: tmo = !ack_g && tmr_hit;
            S_REL: begin
                tmo  = ack_g && tmr_hit;
                step = !ack_g;
            end
            default: ;
        endcase
        if (tmo) begin
            err_d  = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == S_REQ) req_in_d = NEURON_IN'(1) << grant_d;
    end

    // Registered outputs, grant/pointer, timers and per-input budgets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_in_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            grant    <= '0;
            ptr      <= '0;
            tmr      <= '0;
            gcnt     <= '0;
            for (int i = 0; i < int'(NEURON_IN); i++) budget[i] <= '0;
        end else begin
            req_in_q <= req_in_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            grant    <= grant_d;
            if (step) ptr <= wrap_idx(grant, 1);
            tmr  <= (state_d != state) ? '0 : tmr + TMR_W'(1);
            gcnt <= (state_d != state) ? '0 : gcnt + GAP_W'(1);
            for (int i = 0; i < int'(NEURON_IN); i++) begin
                if (tmo)
                    budget[i] <= '0;
                else if (step && grant == IDX_W'(i) && budget[i] != '0)
                    budget[i] <= budget[i] - CNT_W'(1);
                if (load && load_idx == IDX_W'(i))
                    budget[i] <= load_cnt;
            end
        end
    end

    // Output-side 4-phase slaves with saturating counters; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_out_q <= '0;
            spike_cnt <= '0;
        end else begin
            for (int k = 0; k < int'(NEURON_OUT); k++) begin
                if (rq_s2[k] && !ack_out_q[k]) begin
                    ack_out_q[k] <= 1'b1;
                    if (spike_cnt[k*CNT_W +: CNT_W] != '1)
                        spike_cnt[k*CNT_W +: CNT_W] <= spike_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
                end else if (!rq_s2[k]) begin
                    ack_out_q[k] <= 1'b0;
                end
                if (clr_cnt) spike_cnt[k*CNT_W +: CNT_W] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spike_scheduler.sv
// Randomized scoreboard bench for spike_scheduler with a network model.
module tb_spike_scheduler;
    localparam int NIN  = 4;
    localparam int NOUT = 2;
    localparam int CW   = 8;
    localparam int GP   = 2;
    localparam int TMO  = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            load;
    logic [1:0]      load_idx;
    logic [CW-1:0]   load_cnt;
    logic            start;
    logic            clr_cnt;
    logic            busy;
    logic            done;
    logic            err;
    logic [NOUT*CW-1:0] spike_cnt;

    spike_scheduler_if #(.NEURON_IN(NIN), .NEURON_OUT(NOUT)) sif ();

    spike_scheduler #(
        .NEURON_IN(NIN), .NEURON_OUT(NOUT), .CNT_W(CW), .GAP(GP), .TIMEOUT(TMO)
    ) u_dut (
        .clk(clk), .rst(rst), .load(load), .load_idx(load_idx), .load_cnt(load_cnt),
        .start(start), .clr_cnt(clr_cnt), .busy(busy), .done(done), .err(err),
        .spike_cnt(spike_cnt), .net(sif)
    );

    always #5 clk = ~clk;

    int chk  = 0;
    int errs = 0;
    int exp_grant [$];
    bit exp_done  [$];
    int mb [NIN];
    int mptr;
    int ack_dly;
    bit ack_en;

    task automatic check(input string name, input longint act, input longint exp);
        chk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: first input with budget left at or after the pointer, or -1.
    function automatic int model_pick();
        for (int i = 0; i < NIN; i++)
            if (mb[(mptr + i) % NIN] > 0) return (mptr + i) % NIN;
        return -1;
    endfunction

    // Reference for a whole successful run: every grant in order, then one done.
    task automatic model_run();
        int g;
        g = model_pick();
        while (g >= 0) begin
            exp_grant.push_back(g);
            mb[g]--;
            mptr = (g + 1) % NIN;
            g = model_pick();
        end
        exp_done.push_back(1'b0);
    endtask

    task automatic load_budget(input int idx, input int cnt);
        @(posedge clk); #1;
        load = 1'b1; load_idx = 2'(idx); load_cnt = CW'(cnt);
        mb[idx] = cnt;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_grant.size() != 0 || exp_done.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_grant.size() + exp_done.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (sif.req_in == '0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_in_seen", sif.req_in != '0, 1);
    endtask

    // Output-side network model: num 4-phase spikes on channel k.
    task automatic spikes(input int k, input int num, output int lat);
        int n;
        lat = -1;
        for (int s = 0; s < num; s++) begin
            sif.req_out[k] = 1'b1;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!sif.ack_out[k] && n < 20);
            if (s == 0) lat = n;
            check("ack_out_rise", sif.ack_out[k], 1);
            sif.req_out[k] = 1'b0;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (sif.ack_out[k] && n < 20);
            check("ack_out_fall", sif.ack_out[k], 0);
        end
    endtask

    // Input-side network model: ack follows req after a delay (or never when disabled).
    initial begin : network
        int wc [NIN];
        sif.ack_in = '0;
        foreach (wc[i]) wc[i] = -1;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                sif.ack_in = '0;
                foreach (wc[i]) wc[i] = -1;
            end else begin
                for (int i = 0; i < NIN; i++) begin
                    if (sif.req_in[i] == sif.ack_in[i] || (sif.req_in[i] && !ack_en)) begin
                        wc[i] = -1;
                    end else begin
                        if (wc[i] < 0) wc[i] = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 6));
                        wc[i]--;
                        if (wc[i] <= 0) begin
                            sif.ack_in[i] = sif.req_in[i];
                            wc[i] = -1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops expected grants on each new request and expected dones on each pulse.
    initial begin : monitor
        logic [NIN-1:0] prev;
        int g;
        int eg;
        bit ed;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = '0;
                continue;
            end
            check("req_in_onehot", $countones(sif.req_in) <= 1, 1);
            if (sif.req_in != '0 && prev == '0) begin
                g = 0;
                for (int i = 0; i < NIN; i++) if (sif.req_in[i]) g = i;
                check("grant_expected", exp_grant.size() > 0, 1);
                if (exp_grant.size() > 0) begin
                    eg = exp_grant.pop_front();
                    check("grant_index", g, eg);
                end
            end
            prev = sif.req_in;
            if (done) begin
                check("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    ed = exp_done.pop_front();
                    check("err_at_done", err, ed);
                    check("busy_at_done", busy, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat0, lat1, n, tot;
        rst = 1'b0; load = 1'b0; load_idx = '0; load_cnt = '0;
        start = 1'b0; clr_cnt = 1'b0; sif.req_out = '0;
        ack_dly = 5; ack_en = 1'b1; mptr = 0;
        foreach (mb[i]) mb[i] = 0;

        repeat (3) @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req_in", sif.req_in, 0);
        check("rst_ack_out", sif.ack_out, 0);
        check("rst_spike_cnt", spike_cnt, 0);
        rst = 1'b1;

        // Budgets {3,0,2,1}, fixed ack delay.
        load_budget(0, 3); load_budget(1, 0); load_budget(2, 2); load_budget(3, 1);
        model_run();
        pulse_start();
        check("busy_after_start", busy, 1);
        drain("plan_run_drain");
        check("plan_run_err", err, 0);

        // Load while idle must not start; then start-to-request latency.
        load_budget(1, 1);
        repeat (20) @(posedge clk); #1;
        check("idle_load_no_busy", busy, 0);
        model_run();
        pulse_start();
        check("req_in_in_arb", sif.req_in, 0);
        @(posedge clk); #1;
        check("req_in_two_cycles", sif.req_in, 4'b0010);
        drain("single_drain");

        // Randomized budgets and ack delays; a repeated start while busy is ignored.
        ack_dly = 0;
        for (int r = 0; r < 8; r++) begin
            tot = 0;
            for (int i = 0; i < NIN; i++) begin
                n = int'($urandom_range(0, 4));
                tot += n;
                load_budget(i, n);
            end
            model_run();
            pulse_start();
            if (tot > 0 && (r % 2) == 1) pulse_start();
            drain("random_drain");
        end

        // Timeout: acks never arrive.
        ack_en = 1'b0;
        load_budget(3, 2); load_budget(1, 1);
        exp_grant.push_back(model_pick());
        exp_done.push_back(1'b1);
        foreach (mb[i]) mb[i] = 0;
        pulse_start();
        wait_req();
        n = 0;
        while (!err && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk++;
        if (n < TMO || n > TMO + 3) begin
            errs++;
            $display("FAIL timeout_cycles actual=%0d expected=%0d..%0d", n, TMO, TMO + 3);
        end
        check("timeout_req_in", sif.req_in, 0);
        drain("timeout_drain");
        ack_en = 1'b1;
        model_run();
        pulse_start();
        check("start_clears_err", err, 0);
        drain("after_timeout_drain");

        // Output spikes: channel 1 saturates, channel 0 independent.
        fork
            spikes(1, 300, lat1);
            spikes(0, 7, lat0);
        join
        check("ack_out1_latency", lat1, 3);
        check("ack_out0_latency", lat0, 3);
        check("spike_cnt1_sat", spike_cnt[15:8], 255);
        check("spike_cnt0", spike_cnt[7:0], 7);

        // Clear coinciding with an increment on output 0.
        @(posedge clk); #1; sif.req_out[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; clr_cnt = 1'b1;
        @(posedge clk); #1; clr_cnt = 1'b0;
        check("clr_ack_out0", sif.ack_out[0], 1);
        check("clr_wins_cnt", spike_cnt, 0);
        sif.req_out[0] = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("clr_ack_out0_fall", sif.ack_out[0], 0);

        // Reset in the middle of a request.
        ack_en = 1'b0;
        load_budget(2, 1);
        exp_grant.push_back(model_pick());
        sif.req_out[1] = 1'b1;
        pulse_start();
        wait_req();
        repeat (3) @(posedge clk); #1;
        check("pre_rst_ack_out1", sif.ack_out[1], 1);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid_req_in", sif.req_in, 0);
        check("rst_mid_ack_out", sif.ack_out, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_spike_cnt", spike_cnt, 0);
        exp_grant.delete();
        exp_done.delete();
        foreach (mb[i]) mb[i] = 0;
        mptr = 0;
        sif.req_out = '0;
        ack_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_run();
        pulse_start();
        drain("post_rst_empty_drain");
        load_budget(1, 1); load_budget(2, 2); load_budget(3, 1);
        model_run();
        pulse_start();
        drain("post_rst_run_drain");

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule
